// File: rtl/core_sequencer_if.sv
// Core-to-sequencer signal bundle: memory req/ack handshakes, control-unit qualifiers and
// the sequencer's strobes/status. The sequencer uses the master modport.
interface core_sequencer_if #(
   parameter int CNT_W = 32
);
   logic             imem_req;
   logic             imem_ack;
   logic             dmem_req;
   logic             dmem_ack;
   logic             dmem_we;
   logic             Load;
   logic             Store;
   logic             reg_write;
   logic             illegal;
   logic             instr_valid;
   logic             pc_en;
   logic             rf_we;
   logic             halted;
   logic             bus_err;
   logic [2:0]       state;
   logic [CNT_W-1:0] instret;

   modport master (
      input  imem_ack, dmem_ack, Load, Store, reg_write, illegal,
      output imem_req, dmem_req, dmem_we, instr_valid, pc_en, rf_we,
             halted, bus_err, state, instret
   );

   modport slave (
      output imem_ack, dmem_ack, Load, Store, reg_write, illegal,
      input  imem_req, dmem_req, dmem_we, instr_valid, pc_en, rf_we,
             halted, bus_err, state, instret
   );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I sequencer: fetch/exec/mem/writeback stepping with req/ack memory
// handshakes, bus-timeout and illegal-instruction halt, and a retired-instruction counter.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | one cycle after reset release
//   FETCH | imem_req held until imem_ack or timeout
//   EXEC  | decode strobe; commit ALU ops, branch to MEM or HALT
//   MEM   | dmem_req held until dmem_ack or timeout; stores commit here
//   WB    | load writeback and commit
//   HALT  | stopped until reset; bus_err tells timeout from illegal
module core_sequencer #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input logic               clk,
   input logic               rst,
   core_sequencer_if.master  bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_MEM   = 3'd3;
   localparam logic [2:0] S_WB    = 3'd4;
   localparam logic [2:0] S_HALT  = 3'd5;

   localparam int              TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

   logic [2:0]       state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             bus_err_q, bus_err_d;
   logic [CNT_W-1:0] instret_q;
   logic             commit;
   logic             tmr_tc;

   // Wait timer counts down from TIMEOUT-1; reaching zero with no ack is the timeout.
   assign tmr_tc = (timer_q == '0);

   always_comb begin
      state_d   = state_q;
      timer_d   = TMR_LOAD;
      bus_err_d = bus_err_q;
      commit    = 1'b0;
      case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: begin
            if (bus.imem_ack) begin
               state_d = S_EXEC;
            end else if (tmr_tc) begin
               state_d   = S_HALT;
               bus_err_d = 1'b1;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         S_EXEC: begin
            if (bus.illegal) begin
               state_d = S_HALT;
            end else if (bus.Load || bus.Store) begin
               state_d = S_MEM;
            end else begin
               commit  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_MEM: begin
            // Load and Store together behaves as a store.
            if (bus.dmem_ack) begin
               if (bus.Store) begin
                  commit  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (tmr_tc) begin
               state_d   = S_HALT;
               bus_err_d = 1'b1;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         S_WB: begin
            commit  = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         bus_err_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bus_err_q <= bus_err_d;
         if (commit) begin
            instret_q <= instret_q + CNT_W'(1);
         end
      end
   end

   assign bus.imem_req    = (state_q == S_FETCH);
   assign bus.dmem_req    = (state_q == S_MEM);
   assign bus.dmem_we     = (state_q == S_MEM) && bus.Store;
   assign bus.instr_valid = (state_q == S_EXEC);
   assign bus.pc_en       = commit;
   assign bus.rf_we       = commit && ((state_q == S_WB) || ((state_q == S_EXEC) && bus.reg_write));
   assign bus.halted      = (state_q == S_HALT);
   assign bus.bus_err     = bus_err_q;
   assign bus.state       = state_q;
   assign bus.instret     = instret_q;
endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: instruction-level programs expand into per-cycle input and
// expected-output traces, compared every cycle, plus literal checks on key run totals.
module tb_core_sequencer;
   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 4;

   localparam int K_ALU   = 0;
   localparam int K_LOAD  = 1;
   localparam int K_STORE = 2;
   localparam int K_ILL   = 3;
   localparam int K_BOTH  = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;

   core_sequencer_if #(.CNT_W(CNT_W)) bus ();

   core_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic imem_ack, dmem_ack, load, store, reg_write, illegal;
   } in_t;

   typedef struct packed {
      logic [2:0]       state;
      logic             ireq, dreq, dwe, iv, pc, rf, halt, berr;
      logic [CNT_W-1:0] instret;
   } out_t;

   in_t  in_q[$];
   out_t exp_q[$];
   int   retired;
   bit   halted_m;
   int   errors = 0;
   int   checks = 0;

   int   cnt_ireq, cnt_dreq, cnt_dwe, cnt_pc, cnt_rf, cnt_iv;
   logic [2:0] st_log[$];
   out_t last_out;

   function automatic out_t mk(int st, bit ireq, bit dreq, bit dwe, bit iv, bit pc, bit rf,
                               bit halt, bit berr);
      out_t o;
      o.state   = 3'(st);
      o.ireq    = ireq;
      o.dreq    = dreq;
      o.dwe     = dwe;
      o.iv      = iv;
      o.pc      = pc;
      o.rf      = rf;
      o.halt    = halt;
      o.berr    = berr;
      o.instret = CNT_W'(retired);
      return o;
   endfunction

   function automatic in_t mi(bit ia, bit da, bit ld, bit st, bit rw, bit il);
      in_t c;
      c.imem_ack  = ia;
      c.dmem_ack  = da;
      c.load      = ld;
      c.store     = st;
      c.reg_write = rw;
      c.illegal   = il;
      return c;
   endfunction

   task automatic push(in_t c, out_t e);
      in_q.push_back(c);
      exp_q.push_back(e);
   endtask

   task automatic begin_program();
      in_q.delete();
      exp_q.delete();
      retired  = 0;
      halted_m = 1'b0;
      push(mi(0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic add_halt(bit berr);
      halted_m = 1'b1;
      for (int i = 0; i < 3; i++)
         push(mi(1, 1, 1, 1, 1, 0), mk(5, 0, 0, 0, 0, 0, 0, 1, berr));
   endtask

   // One instruction: iwait/dwait = cycles without ack before the ack cycle;
   // a wait of TIMEOUT or more means the ack never comes.
   task automatic add_instr(int kind, bit rw, int iwait, int dwait, bit stray);
      bit ld, st, il;
      if (halted_m) return;
      ld = (kind == K_LOAD) || (kind == K_BOTH) || (kind == K_ILL);
      st = (kind == K_STORE) || (kind == K_BOTH);
      il = (kind == K_ILL);
      for (int i = 0; i <= iwait && i < TIMEOUT; i++)
         push(mi(i == iwait, stray, ld, st, rw, il), mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
      if (iwait >= TIMEOUT) begin
         add_halt(1'b1);
         return;
      end
      if (il) begin
         push(mi(stray, stray, ld, st, rw, il), mk(2, 0, 0, 0, 1, 0, 0, 0, 0));
         add_halt(1'b0);
         return;
      end
      if (!ld && !st) begin
         push(mi(stray, stray, ld, st, rw, il), mk(2, 0, 0, 0, 1, 1, rw, 0, 0));
         retired++;
         return;
      end
      push(mi(stray, stray, ld, st, rw, il), mk(2, 0, 0, 0, 1, 0, 0, 0, 0));
      for (int i = 0; i <= dwait && i < TIMEOUT; i++) begin
         push(mi(stray, i == dwait, ld, st, rw, il),
              mk(3, 0, 1, st, 0, (i == dwait) && st, 0, 0, 0));
         if (i == dwait && st) retired++;
      end
      if (dwait >= TIMEOUT) begin
         add_halt(1'b1);
         return;
      end
      if (!st) begin
         push(mi(stray, stray, ld, st, rw, il), mk(4, 0, 0, 0, 0, 1, 1, 0, 0));
         retired++;
      end
   endtask

   task automatic add_tail();
      if (!halted_m) push(mi(0, 0, 0, 0, 0, 0), mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic apply(in_t c);
      bus.imem_ack  = c.imem_ack;
      bus.dmem_ack  = c.dmem_ack;
      bus.Load      = c.load;
      bus.Store     = c.store;
      bus.reg_write = c.reg_write;
      bus.illegal   = c.illegal;
   endtask

   function automatic out_t sample();
      out_t o;
      o.state   = bus.state;
      o.ireq    = bus.imem_req;
      o.dreq    = bus.dmem_req;
      o.dwe     = bus.dmem_we;
      o.iv      = bus.instr_valid;
      o.pc      = bus.pc_en;
      o.rf      = bus.rf_we;
      o.halt    = bus.halted;
      o.berr    = bus.bus_err;
      o.instret = bus.instret;
      return o;
   endfunction

   task automatic check_out(string name, int cyc, out_t e);
      out_t got;
      got = sample();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL %s cyc%0d: got st=%0d ireq=%b dreq=%b dwe=%b iv=%b pc=%b rf=%b halt=%b berr=%b instret=%0d, expected st=%0d ireq=%b dreq=%b dwe=%b iv=%b pc=%b rf=%b halt=%b berr=%b instret=%0d",
                  name, cyc, got.state, got.ireq, got.dreq, got.dwe, got.iv, got.pc, got.rf,
                  got.halt, got.berr, got.instret, e.state, e.ireq, e.dreq, e.dwe, e.iv, e.pc,
                  e.rf, e.halt, e.berr, e.instret);
      end
   endtask

   task automatic lit(string name, int got, int expv);
      checks++;
      if (got != expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, expv);
      end
   endtask

   task automatic run_program(string name);
      in_t  c;
      out_t e;
      int   cyc;
      rst = 1'b0;
      apply(mi(0, 0, 0, 0, 0, 0));
      @(posedge clk);
      @(negedge clk);
      check_out({name, "/reset"}, 0, '0);
      cnt_ireq = 0; cnt_dreq = 0; cnt_dwe = 0; cnt_pc = 0; cnt_rf = 0; cnt_iv = 0;
      st_log.delete();
      cyc = 0;
      @(posedge clk);
      #1 rst = 1'b1;
      while (in_q.size() > 0) begin
         c = in_q.pop_front();
         e = exp_q.pop_front();
         apply(c);
         @(negedge clk);
         check_out(name, cyc, e);
         last_out = sample();
         st_log.push_back(last_out.state);
         cnt_ireq += int'(last_out.ireq);
         cnt_dreq += int'(last_out.dreq);
         cnt_dwe  += int'(last_out.dwe);
         cnt_pc   += int'(last_out.pc);
         cnt_rf   += int'(last_out.rf);
         cnt_iv   += int'(last_out.iv);
         cyc++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      apply(mi(0, 0, 0, 0, 0, 0));

      begin_program();
      add_instr(K_ALU, 1, 0, 0, 0);
      add_tail();
      run_program("alu");
      lit("alu_states", int'({st_log[0], st_log[1], st_log[2], st_log[3]}),
          int'({3'd0, 3'd1, 3'd2, 3'd1}));
      lit("alu_pc", cnt_pc, 1);
      lit("alu_rf", cnt_rf, 1);
      lit("alu_instret", int'(last_out.instret), 1);

      begin_program();
      add_instr(K_LOAD, 0, 0, 3, 0);
      add_tail();
      run_program("load");
      lit("load_dreq", cnt_dreq, 4);
      lit("load_dwe", cnt_dwe, 0);
      lit("load_rf", cnt_rf, 1);
      lit("load_instret", int'(last_out.instret), 1);

      begin_program();
      add_instr(K_STORE, 1, 1, 1, 1);
      add_tail();
      run_program("store");
      lit("store_dwe", cnt_dwe, 2);
      lit("store_rf", cnt_rf, 0);
      lit("store_pc", cnt_pc, 1);
      lit("store_next_state", int'(last_out.state), 1);

      begin_program();
      add_instr(K_ALU, 1, TIMEOUT, 0, 1);
      run_program("ifetch_timeout");
      lit("to_ireq", cnt_ireq, 4);
      lit("to_halted", int'(last_out.halt), 1);
      lit("to_bus_err", int'(last_out.berr), 1);
      lit("to_state", int'(last_out.state), 5);

      begin_program();
      add_instr(K_ALU, 0, TIMEOUT - 1, 0, 0);
      add_instr(K_STORE, 0, 0, TIMEOUT - 1, 0);
      add_tail();
      run_program("last_cycle_ack");
      lit("lca_pc", cnt_pc, 2);
      lit("lca_bus_err", int'(last_out.berr), 0);
      lit("lca_instret", int'(last_out.instret), 2);

      begin_program();
      add_instr(K_ALU, 1, 0, 0, 0);
      add_instr(K_ILL, 1, 0, 0, 0);
      run_program("illegal");
      lit("ill_halted", int'(last_out.halt), 1);
      lit("ill_bus_err", int'(last_out.berr), 0);
      lit("ill_pc", cnt_pc, 1);
      lit("ill_dreq", cnt_dreq, 0);

      begin_program();
      add_instr(K_BOTH, 1, 0, 2, 0);
      add_instr(K_LOAD, 0, 1, TIMEOUT + 2, 0);
      run_program("both_then_dmem_timeout");
      lit("bt_dwe", cnt_dwe, 3);
      lit("bt_bus_err", int'(last_out.berr), 1);
      lit("bt_instret", int'(last_out.instret), 1);

      begin_program();
      for (int i = 0; i < 17; i++)
         add_instr((i % 3 == 0) ? K_ALU : ((i % 3 == 1) ? K_LOAD : K_STORE), i[0], i % 3, i % 4, i[1]);
      add_tail();
      run_program("wrap");
      lit("wrap_pc", cnt_pc, 17);
      lit("wrap_instret", int'(last_out.instret), 1);

      // Async reset while a data request is outstanding.
      rst = 1'b0;
      apply(mi(1, 0, 1, 0, 1, 0));
      @(posedge clk);
      #1 rst = 1'b1;
      begin
         int n;
         n = 0;
         while (bus.state != 3'd3 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
         end
         lit("midmem_reached", int'(bus.state == 3'd3), 1);
      end
      #1 rst = 1'b0;
      #1 check_out("midmem_async_reset", 0, '0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      lit("midmem_idle", int'(bus.state), 0);
      @(posedge clk);
      @(negedge clk);
      lit("midmem_fetch", int'(bus.state), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
